// File: rtl/ob_rd_pkg.sv
// Shared constants, FSM states and beat tag type for the outbound-buffer read scheduler.
package ob_rd_pkg;

  localparam int unsigned NUM_BANK = 8;
  localparam int unsigned ENTRY_W  = 8;
  localparam int unsigned DATA_W   = 128;
  localparam int unsigned CH_W     = $clog2(NUM_BANK);

  typedef enum logic {
    S_IDLE,
    S_BURST
  } state_e;

  typedef struct packed {
    logic [CH_W-1:0] ch;
    logic            last;
  } tag_t;

  // Bank occupies the nibble above the entry byte; upper bits stay zero.
  function automatic logic [31:0] rd_addr(input logic [CH_W-1:0]    ch,
                                          input logic [ENTRY_W-1:0] entry);
    return {{(32 - CH_W - ENTRY_W){1'b0}}, ch, entry};
  endfunction

endpackage

// File: rtl/ob_rd_fifo.sv
// Synchronous FIFO holding returned beats; read data is presented from the head entry.
module ob_rd_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 132
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_q, rd_q;
  logic [CNT_W-1:0] cnt_q;
  logic             do_push, do_pop;

  assign full     = (cnt_q == CNT_W'(DEPTH));
  assign empty    = (cnt_q == '0);
  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;
  assign pop_data = mem_q[rd_q];

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= ptr_inc(wr_q);
      if (do_pop)  rd_q <= ptr_inc(rd_q);
      if (do_push && !do_pop)      cnt_q <= cnt_q + CNT_W'(1);
      else if (!do_push && do_pop) cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= push_data;
  end

endmodule

// File: rtl/ob_rd_sched.sv
// Round-robin burst read scheduler for the shared port of the 8-bank outbound buffer,
// returning tagged beats through a credit-controlled output FIFO.
module ob_rd_sched
  import ob_rd_pkg::*;
#(
  parameter int unsigned NUM_CH     = 8,
  parameter int unsigned RD_LAT     = 1,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_CH-1:0]               req_vld,
  output logic [NUM_CH-1:0]               req_rdy,
  input  logic [NUM_CH-1:0][ENTRY_W-1:0]  req_addr,
  input  logic [NUM_CH-1:0][ENTRY_W-1:0]  req_len,
  output logic                            RdEn,
  output logic [31:0]                     RdAddr,
  input  logic [DATA_W-1:0]               RdData,
  output logic                            out_vld,
  input  logic                            out_rdy,
  output logic [DATA_W-1:0]               out_data,
  output logic [CH_W-1:0]                 out_ch,
  output logic                            out_last
);

  localparam int unsigned OCC_W  = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned FIFO_W = DATA_W + $bits(tag_t);

  state_e             state_q, state_d;
  logic [CH_W-1:0]    ch_q, ch_d, rr_q, rr_d;
  logic [ENTRY_W-1:0] entry_q, entry_d, cnt_q, cnt_d;
  logic [OCC_W-1:0]   occ_q, occ_d;
  logic               credit_ok, rd_en;
  logic               any_req;
  logic [CH_W-1:0]    gnt_idx;

  logic [RD_LAT-1:0]       tv_q;
  tag_t [RD_LAT-1:0]       tag_q;
  logic                    fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [FIFO_W-1:0]       fifo_rdata;
  logic [DATA_W-1:0]       head_data;
  tag_t                    head_tag;

  // First requester at or after rr_q, scanning modulo NUM_CH.
  always_comb begin
    logic [31:0]     c;
    logic [CH_W-1:0] c_idx;
    any_req = 1'b0;
    gnt_idx = '0;
    c       = '0;
    c_idx   = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      c     = (32'(rr_q) + i) % NUM_CH;
      c_idx = CH_W'(c);
      if (!any_req && req_vld[c_idx]) begin
        any_req = 1'b1;
        gnt_idx = c_idx;
      end
    end
  end

  assign credit_ok = (occ_q < OCC_W'(FIFO_DEPTH));

  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    entry_d = entry_q;
    cnt_d   = cnt_q;
    rr_d    = rr_q;
    req_rdy = '0;
    rd_en   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (any_req && !rst) begin
          req_rdy[gnt_idx] = 1'b1;
          ch_d    = gnt_idx;
          entry_d = req_addr[gnt_idx];
          cnt_d   = req_len[gnt_idx];
          rr_d    = (gnt_idx == CH_W'(NUM_CH - 1)) ? '0 : gnt_idx + CH_W'(1);
          state_d = S_BURST;
        end
      end
      S_BURST: begin
        if (credit_ok && !rst) begin
          rd_en   = 1'b1;
          entry_d = entry_q + ENTRY_W'(1);
          cnt_d   = cnt_q - ENTRY_W'(1);
          if (cnt_q == '0) state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign RdEn   = rd_en;
  assign RdAddr = rd_en ? rd_addr(ch_q, entry_q) : '0;

  assign fifo_pop = out_vld & out_rdy;

  always_comb begin
    occ_d = occ_q;
    if (rd_en && !fifo_pop)      occ_d = occ_q + OCC_W'(1);
    else if (!rd_en && fifo_pop) occ_d = occ_q - OCC_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      ch_q    <= '0;
      rr_q    <= '0;
      entry_q <= '0;
      cnt_q   <= '0;
      occ_q   <= '0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      rr_q    <= rr_d;
      entry_q <= entry_d;
      cnt_q   <= cnt_d;
      occ_q   <= occ_d;
    end
  end

  // Tags ride alongside the RAM latency so each returning word knows its channel.
  always_ff @(posedge clk) begin
    if (rst) begin
      tv_q  <= '0;
      tag_q <= '0;
    end else begin
      tv_q[0]  <= rd_en;
      tag_q[0] <= '{ch: ch_q, last: (cnt_q == '0)};
      for (int unsigned i = 1; i < RD_LAT; i++) begin
        tv_q[i]  <= tv_q[i-1];
        tag_q[i] <= tag_q[i-1];
      end
    end
  end

  assign fifo_push = tv_q[RD_LAT-1] & ~fifo_full;

  ob_rd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (FIFO_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data ({RdData, tag_q[RD_LAT-1]}),
    .pop       (fifo_pop),
    .pop_data  (fifo_rdata),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign {head_data, head_tag} = fifo_rdata;

  always_comb begin
    out_vld  = ~fifo_empty;
    out_data = '0;
    out_ch   = '0;
    out_last = 1'b0;
    if (out_vld) begin
      out_data = head_data;
      out_ch   = head_tag.ch;
      out_last = head_tag.last;
    end
  end

endmodule

// File: tb/tb_ob_rd_sched.sv
// Bench for ob_rd_sched: directed scenarios plus random traffic, checked against a
// transaction-level model of grants, issue slots and returned beats.
module tb_ob_rd_sched;
  import ob_rd_pkg::*;

  localparam int unsigned NUM_CH     = 8;
  localparam int unsigned RD_LAT     = 1;
  localparam int unsigned FIFO_DEPTH = 4;

  logic                       clk = 1'b0;
  logic                       rst;
  logic [NUM_CH-1:0]          req_vld;
  logic [NUM_CH-1:0]          req_rdy;
  logic [NUM_CH-1:0][7:0]     req_addr;
  logic [NUM_CH-1:0][7:0]     req_len;
  logic                       RdEn;
  logic [31:0]                RdAddr;
  logic [127:0]               RdData;
  logic                       out_vld;
  logic                       out_rdy;
  logic [127:0]               out_data;
  logic [2:0]                 out_ch;
  logic                       out_last;

  always #5 clk = ~clk;

  ob_rd_sched #(
    .NUM_CH     (NUM_CH),
    .RD_LAT     (RD_LAT),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req_vld  (req_vld),
    .req_rdy  (req_rdy),
    .req_addr (req_addr),
    .req_len  (req_len),
    .RdEn     (RdEn),
    .RdAddr   (RdAddr),
    .RdData   (RdData),
    .out_vld  (out_vld),
    .out_rdy  (out_rdy),
    .out_data (out_data),
    .out_ch   (out_ch),
    .out_last (out_last)
  );

  // Bank RAM contents are a fixed function of the full read address.
  function automatic logic [127:0] ram_word(input logic [31:0] a);
    return {a * 32'h9E37_79B1, ~a, a ^ 32'h5A5A_0000, 32'hC0DE_0000 | a};
  endfunction

  logic [127:0] rd_pipe [RD_LAT];
  always @(posedge clk) begin
    rd_pipe[0] <= RdEn ? ram_word(RdAddr) : '0;
    for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign RdData = rd_pipe[RD_LAT-1];

  typedef struct {
    logic [127:0] data;
    logic [2:0]   ch;
    logic         last;
    int           rdy_cyc;
  } beat_t;

  // Reference model state
  bit          m_busy;
  int          m_ch, m_rr, m_rem, m_occ;
  logic [7:0]  m_entry;
  beat_t       outq[$];
  int          grant_log[$];
  bit [NUM_CH-1:0] granted;

  int cyc, n_vec, n_err;
  int n_rden, n_out, n_last, rden_first, rden_last;
  bit chk_occ;

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 1'b0;
    m_rr   = 0;
    m_occ  = 0;
    m_rem  = 0;
    outq.delete();
    granted = '0;
  endtask

  task automatic clr_stats();
    n_rden = 0; n_out = 0; n_last = 0; rden_first = -1; rden_last = -1;
  endtask

  task automatic request(input int c, input logic [7:0] a, input logic [7:0] l);
    req_vld[c]  = 1'b1;
    req_addr[c] = a;
    req_len[c]  = l;
  endtask

  // One clock: check DUT against the model at the falling edge, then advance both.
  task automatic tick();
    logic [NUM_CH-1:0] exp_rdy;
    int    g, c;
    bit    exp_en, exp_ov;
    beat_t b;
    logic [31:0] a;
    @(negedge clk);
    if (rst) begin
      model_reset();
    end else begin
      exp_rdy = '0;
      g = -1;
      if (!m_busy) begin
        for (int i = 0; i < NUM_CH; i++) begin
          c = (m_rr + i) % NUM_CH;
          if (g < 0 && req_vld[c]) g = c;
        end
      end
      if (g >= 0) exp_rdy[g] = 1'b1;
      chk("req_rdy", req_rdy, exp_rdy);

      exp_en = m_busy && (m_occ < FIFO_DEPTH);
      a = {20'h0, 4'(m_ch), m_entry};
      chk("RdEn", RdEn, exp_en);
      if (exp_en) chk("RdAddr", RdAddr, a);

      exp_ov = (outq.size() > 0) && (outq[0].rdy_cyc <= cyc);
      chk("out_vld", out_vld, exp_ov);
      if (exp_ov) begin
        chk("out_data", out_data, outq[0].data);
        chk("out_ch", out_ch, outq[0].ch);
        chk("out_last", out_last, outq[0].last);
      end else begin
        chk("out_idle_zero", {out_data, out_ch, out_last}, '0);
      end
      if (chk_occ) chk("occ_bound", (dut.occ_q <= RD_LAT + 1), 1'b1);

      if (RdEn) begin
        n_rden++;
        if (rden_first < 0) rden_first = cyc;
        rden_last = cyc;
      end
      if (out_vld && out_rdy) begin
        n_out++;
        if (out_last) n_last++;
      end

      if (exp_ov && out_rdy) begin
        void'(outq.pop_front());
        m_occ--;
      end
      if (exp_en) begin
        b.data = ram_word(a); b.ch = 3'(m_ch); b.last = (m_rem == 1);
        b.rdy_cyc = cyc + RD_LAT + 1;
        outq.push_back(b);
        m_occ++;
        m_entry = m_entry + 8'd1;
        m_rem--;
        if (m_rem == 0) m_busy = 1'b0;
      end
      if (g >= 0) begin
        grant_log.push_back(g);
        m_busy  = 1'b1;
        m_ch    = g;
        m_entry = req_addr[g];
        m_rem   = int'(req_len[g]) + 1;
        m_rr    = (g + 1) % NUM_CH;
        granted[g] = 1'b1;
      end
    end
    @(posedge clk);
    cyc++;
    #1;
    for (int i = 0; i < NUM_CH; i++) if (granted[i]) req_vld[i] = 1'b0;
    granted = '0;
  endtask

  task automatic run_until_idle(input int max, input string tag);
    int k = 0;
    while ((m_busy || (|req_vld) || outq.size() > 0) && k < max) begin
      tick();
      k++;
    end
    chk(tag, (m_busy || (|req_vld) || outq.size() > 0), 1'b0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_req_rdy"}, req_rdy, '0);
    chk({tag, "_rd"}, {RdEn, RdAddr}, '0);
    chk({tag, "_out"}, {out_vld, out_data, out_ch, out_last}, '0);
  endtask

  initial begin
    int k;
    n_vec = 0; n_err = 0; cyc = 0; chk_occ = 1'b0;
    rst = 1'b1; req_vld = '0; req_addr = '0; req_len = '0; out_rdy = 1'b1;
    model_reset();
    clr_stats();
    tick();
    tick();
    rst = 1'b0;
    chk_zero("reset");

    // Single 4-beat burst from ch3
    clr_stats();
    request(3, 8'h10, 8'd3);
    run_until_idle(50, "single_done");
    chk("single_beats", n_out, 4);
    chk("single_lasts", n_last, 1);

    // Entry wrap stays within bank 0
    clr_stats();
    request(0, 8'hFE, 8'd3);
    run_until_idle(50, "wrap_done");
    chk("wrap_beats", n_out, 4);

    // Round-robin order with ch1 re-requesting right after its grant
    grant_log.delete();
    request(1, 8'h01, 8'd0);
    request(2, 8'h02, 8'd0);
    request(5, 8'h05, 8'd0);
    tick();
    request(1, 8'h40, 8'd0);
    run_until_idle(50, "rr_done");
    chk("rr_count", grant_log.size(), 4);
    if (grant_log.size() == 4)
      chk("rr_order", {8'(grant_log[0]), 8'(grant_log[1]), 8'(grant_log[2]), 8'(grant_log[3])},
          32'h01020501);

    // Backpressure: only FIFO_DEPTH issues before stalling
    clr_stats();
    out_rdy = 1'b0;
    request(2, 8'h80, 8'd7);
    repeat (12) tick();
    chk("bp_issue_stall", n_rden, FIFO_DEPTH);
    out_rdy = 1'b1;
    run_until_idle(60, "bp_done");
    chk("bp_issue_total", n_rden, 8);
    chk("bp_beats", n_out, 8);

    // 256-beat burst with continuous drain
    clr_stats();
    chk_occ = 1'b1;
    request(7, 8'h00, 8'd255);
    run_until_idle(400, "long_done");
    chk_occ = 1'b0;
    chk("long_issue", n_rden, 256);
    chk("long_contig", rden_last - rden_first + 1, 256);
    chk("long_last_once", n_last, 1);
    chk("long_beats", n_out, 256);

    // Reset during the third beat of an 8-beat burst
    clr_stats();
    request(4, 8'h20, 8'd7);
    k = 0;
    while (n_rden < 2 && k < 20) begin
      tick();
      k++;
    end
    chk("rst_setup", n_rden, 2);
    rst = 1'b1;
    req_vld = '0;
    tick();
    rst = 1'b0;
    chk_zero("post_rst");
    chk("post_rst_idle", (dut.state_q == S_IDLE), 1'b1);
    clr_stats();
    grant_log.delete();
    request(6, 8'h60, 8'd1);
    request(0, 8'h30, 8'd1);
    run_until_idle(50, "post_rst_done");
    chk("post_rst_first_grant", (grant_log.size() > 0) ? grant_log[0] : -1, 0);
    chk("post_rst_beats", n_out, 4);

    // Random traffic with random consumer stalls
    clr_stats();
    for (int i = 0; i < 400; i++) begin
      out_rdy = ($urandom_range(0, 3) != 0);
      for (int c = 0; c < NUM_CH; c++)
        if (!req_vld[c] && $urandom_range(0, 15) == 0)
          request(c, 8'($urandom), 8'($urandom_range(0, 9)));
      tick();
    end
    out_rdy = 1'b1;
    run_until_idle(3000, "rand_done");
    chk("rand_issue_vs_out", n_out, n_rden);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
